// File: rtl/cec_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cec_frame_sequencer                                          |
// | Description : Frame-level sequencer for an HDMI-CEC initiator. Holds a     |
// |               16-byte frame buffer, waits for the required signal-free     |
// |               time on the CEC line, feeds bytes one at a time to a byte    |
// |               transmitter and retries the whole frame on a NAK.            |
// | Option      : CEC_RETRY_EN - when defined, a NAKed frame is retried up to  |
// |               MAX_RETRIES times after a 3-bit-period free time; when not   |
// |               defined, any NAK abandons the frame at once.                 |
// | Ports       : clk, rst (async, active-high)                                |
// |               wr_en/wr_addr/wr_data  - frame buffer write port             |
// |               frame_len, send        - frame length and transmit request   |
// |               cec_in                 - synchronised line level (1=free)    |
// |               tx_start/tx_data/tx_eom/tx_broadcast - byte launch to PHY    |
// |               tx_done/tx_acked       - byte completion from PHY            |
// |               busy, frame_ok, frame_fail, retry_count - status             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cec_frame_sequencer #(
    parameter int BIT_PERIOD_CYCLES = 64_800,
    parameter int MAX_RETRIES       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] frame_len,
    input  logic       send,
    input  logic       cec_in,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       tx_eom,
    output logic       tx_broadcast,
    input  logic       tx_done,
    input  logic       tx_acked,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_fail,
    output logic [2:0] retry_count
);

    // Signal-free times: 7 bit periods before a new frame, 3 before a retry.
    localparam logic [19:0] c_FREE_NEW    = 20'(7 * BIT_PERIOD_CYCLES);
    localparam logic [19:0] c_FREE_RETRY  = 20'(3 * BIT_PERIOD_CYCLES);
    localparam logic [2:0]  c_MAX_RETRIES = 3'(MAX_RETRIES);

`ifdef CEC_RETRY_EN
    localparam logic c_RETRY_EN = 1'b1;
`else
    localparam logic c_RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_FREE = 3'd1,
        S_LAUNCH    = 3'd2,
        S_WAIT_BYTE = 3'd3,
        S_NEXT      = 3'd4,
        S_DONE      = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    state_t      r_state;
    logic [7:0]  r_buf [16];
    logic [4:0]  r_len;
    logic [3:0]  r_idx;
    logic [19:0] r_cnt;
    logic [19:0] r_target;

    logic        w_len_valid;
    logic        w_last;
    logic        w_free_reached;
    logic        w_launch;
    logic [3:0]  w_launch_idx;
    logic        w_launch_eom;
    logic        w_bcast;

    // Buffer has no reset and accepts writes in every state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    assign w_len_valid    = (frame_len != 5'd0) && (frame_len <= 5'd16);
    assign w_last         = ({1'b0, r_idx} == (r_len - 5'd1));
    assign w_free_reached = cec_in && ((r_cnt + 20'd1) >= r_target);

    // A byte is launched either after the free time (byte 0) or straight
    // from NEXT for the following byte; tx_* are registered on that edge so
    // tx_start is high for exactly the one cycle spent in LAUNCH.
    assign w_launch     = ((r_state == S_WAIT_FREE) && w_free_reached) ||
                          ((r_state == S_NEXT) && !w_last);
    assign w_launch_idx = (r_state == S_NEXT) ? (r_idx + 4'd1) : 4'd0;
    assign w_launch_eom = ({1'b0, w_launch_idx} == (r_len - 5'd1));
    assign w_bcast      = (r_buf[0][3:0] == 4'hF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= 5'd0;
            r_idx        <= 4'd0;
            r_cnt        <= 20'd0;
            r_target     <= 20'd0;
            busy         <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= 8'd0;
            tx_eom       <= 1'b0;
            tx_broadcast <= 1'b0;
            frame_ok     <= 1'b0;
            frame_fail   <= 1'b0;
            retry_count  <= 3'd0;
        end else begin
            tx_start   <= 1'b0;
            frame_ok   <= 1'b0;
            frame_fail <= 1'b0;

            if (w_launch) begin
                r_idx        <= w_launch_idx;
                tx_data      <= r_buf[w_launch_idx];
                tx_eom       <= w_launch_eom;
                tx_broadcast <= w_bcast;
                tx_start     <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (send) begin
                        if (w_len_valid) begin
                            r_len       <= frame_len;
                            retry_count <= 3'd0;
                            r_target    <= c_FREE_NEW;
                            r_cnt       <= 20'd0;
                            busy        <= 1'b1;
                            r_state     <= S_WAIT_FREE;
                        end else begin
                            frame_fail <= 1'b1;
                            r_state    <= S_FAIL;
                        end
                    end
                end
                S_WAIT_FREE: begin
                    // Any low sample restarts the free-time measurement.
                    if (!cec_in) begin
                        r_cnt <= 20'd0;
                    end else if (w_free_reached) begin
                        r_state <= S_LAUNCH;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT_BYTE;
                end
                S_WAIT_BYTE: begin
                    if (tx_done) begin
                        if (tx_acked) begin
                            r_state <= S_NEXT;
                        end else if (c_RETRY_EN && (retry_count < c_MAX_RETRIES)) begin
                            retry_count <= retry_count + 3'd1;
                            r_target    <= c_FREE_RETRY;
                            r_cnt       <= 20'd0;
                            r_state     <= S_WAIT_FREE;
                        end else begin
                            frame_fail <= 1'b1;
                            r_state    <= S_FAIL;
                        end
                    end
                end
                S_NEXT: begin
                    if (w_last) begin
                        frame_ok <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_state <= S_LAUNCH;
                    end
                end
                S_DONE, S_FAIL: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cec_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cec_frame_sequencer                                       |
// | Description : Randomised scoreboard bench for cec_frame_sequencer. The     |
// |               stimulus side emulates the host and the byte transmitter    |
// |               and queues the expected launches and frame outcomes; a     |
// |               monitor compares them as the DUT presents them.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cec_frame_sequencer;

    localparam int     BP         = 8;
    localparam int     MR         = 5;
    localparam longint FREE_NEW   = 7 * BP;
    localparam longint FREE_RETRY = 3 * BP;
`ifdef CEC_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic [4:0] frame_len = 5'd0;
    logic       send = 1'b0;
    logic       cec_in = 1'b1;
    logic       tx_done = 1'b0;
    logic       tx_acked = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_eom;
    logic       tx_broadcast;
    logic       busy;
    logic       frame_ok;
    logic       frame_fail;
    logic [2:0] retry_count;

    cec_frame_sequencer #(
        .BIT_PERIOD_CYCLES (BP),
        .MAX_RETRIES       (MR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_len    (frame_len),
        .send         (send),
        .cec_in       (cec_in),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_eom       (tx_eom),
        .tx_broadcast (tx_broadcast),
        .tx_done      (tx_done),
        .tx_acked     (tx_acked),
        .busy         (busy),
        .frame_ok     (frame_ok),
        .frame_fail   (frame_fail),
        .retry_count  (retry_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint     cyc;
        logic [7:0] data;
        logic       eom;
        logic       bc;
    } start_t;

    typedef struct {
        longint lo;
        logic   ok;
        int     retries;   // -1: not checked
    } end_t;

    start_t     sq[$];
    end_t       eq[$];
    logic [7:0] mbuf [16];
    longint     cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every launch and every end pulse must match the queue head.
    start_t ms;
    end_t   me;
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                if (sq.size() == 0) begin
                    chk("spurious_tx_start", longint'(tx_start), 0);
                end else begin
                    ms = sq.pop_front();
                    chk("tx_start_cycle", cyc, ms.cyc);
                    chk("tx_data", longint'(tx_data), longint'(ms.data));
                    chk("tx_eom", longint'(tx_eom), longint'(ms.eom));
                    chk("tx_broadcast", longint'(tx_broadcast), longint'(ms.bc));
                    chk("busy_at_launch", longint'(busy), 1);
                end
            end
            if (frame_ok || frame_fail) begin
                if (eq.size() == 0) begin
                    chk("spurious_end_pulse", longint'({frame_ok, frame_fail}), 0);
                end else begin
                    me = eq.pop_front();
                    chk("end_kind", longint'({frame_ok, frame_fail}), me.ok ? 2 : 1);
                    chk("end_latency", longint'(cyc >= me.lo && cyc <= me.lo + 2), 1);
                    if (me.retries >= 0)
                        chk("end_retry_count", longint'(retry_count), longint'(me.retries));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        sq.delete();
        eq.delete();
        rst = 1'b0;
    endtask

    task automatic write_byte(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a[3:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        mbuf[a] = d;
    endtask

    task automatic write_all();
        for (int i = 0; i < 16; i++) write_byte(i, 8'($urandom));
        if ($urandom_range(0, 3) == 0) write_byte(0, {mbuf[0][7:4], 4'hF});
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_start) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    // Free-time phase: optional line glitch (restarts the count), then an
    // optional stray tx_done and a send while busy, both of which must be ignored.
    task automatic wait_free_phase(inout longint l, input longint tgt, input int glitch);
        int k;
        if (glitch == 2 || (glitch == 1 && $urandom_range(0, 3) == 0)) begin
            k = $urandom_range(0, int'(tgt) - 4);
            repeat (k) tick();
            cec_in = 1'b0;
            repeat ($urandom_range(1, 6)) tick();
            l = cyc;
            cec_in = 1'b1;
        end
        if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, int'(tgt) - 4);
            repeat (k) tick();
            tx_done   = 1'b1;
            tx_acked  = 1'($urandom);
            send      = 1'b1;
            frame_len = 5'($urandom_range(1, 16));
            tick();
            tx_done = 1'b0;
            send    = 1'b0;
        end
    endtask

    task automatic wait_end(input int exp_retries);
        int i;
        for (i = 0; i < 20; i++) begin
            if (eq.size() == 0 && !busy) break;
            tick();
        end
        chk("frame_end_in_time", longint'(i < 20), 1);
        chk("pending_tx_start", longint'(sq.size()), 0);
        if (i >= 20) begin
            do_reset();
        end else if (exp_retries >= 0) begin
            chk("retry_count_held", longint'(retry_count), longint'(exp_retries));
        end
        if ($urandom_range(0, 1) == 0) begin
            tx_done  = 1'b1;
            tx_acked = 1'($urandom);
            tick();
            tx_done  = 1'b0;
        end
        repeat ($urandom_range(1, 4)) tick();
    endtask

    // nak_mode: 0 random, 1 always NAK, 2 NAK only byte 0 of attempt 0, 3 always ACK
    function automatic bit decide_ack(input int nak_mode, input int b, input int retries);
        case (nak_mode)
            0:       return ($urandom_range(0, 5) != 0);
            1:       return 1'b0;
            2:       return !(b == 0 && retries == 0);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_frame(input int len, input int nak_mode, input int glitch);
        longint s, l, n, tgt;
        int     retries, b;
        bit     got, ack, bc;
        start_t se;
        end_t   ee;
        frame_len = len[4:0];
        send = 1'b1;
        tick();
        s = cyc;
        send = 1'b0;
        frame_len = 5'($urandom);
        if (len < 1 || len > 16) begin
            ee.lo = s; ee.ok = 1'b0; ee.retries = -1;
            eq.push_back(ee);
            wait_end(-1);
            return;
        end
        bc = (mbuf[0][3:0] == 4'hF);
        retries = 0;
        l = s;
        tgt = FREE_NEW;
        forever begin
            wait_free_phase(l, tgt, glitch);
            se.cyc = l + tgt; se.data = mbuf[0]; se.eom = (len == 1); se.bc = bc;
            sq.push_back(se);
            b = 0;
            forever begin
                wait_start(got);
                if (!got) begin
                    chk("tx_start_timeout", 0, 1);
                    do_reset();
                    return;
                end
                repeat ($urandom_range(1, 5)) tick();
                ack = decide_ack(nak_mode, b, retries);
                tx_done  = 1'b1;
                tx_acked = ack;
                chk("tx_data_held", longint'(tx_data), longint'(mbuf[b]));
                tick();
                n = cyc;
                tx_done  = 1'b0;
                tx_acked = 1'($urandom);
                if (ack) begin
                    if (b == len - 1) begin
                        ee.lo = n; ee.ok = 1'b1; ee.retries = retries;
                        eq.push_back(ee);
                        wait_end(retries);
                        return;
                    end
                    b++;
                    se.cyc = n + 1; se.data = mbuf[b]; se.eom = (b == len - 1); se.bc = bc;
                    sq.push_back(se);
                end else if (RETRY_EN && retries < MR) begin
                    retries++;
                    l = n;
                    tgt = FREE_RETRY;
                    break;
                end else begin
                    ee.lo = n; ee.ok = 1'b0; ee.retries = retries;
                    eq.push_back(ee);
                    wait_end(retries);
                    return;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_tx_start"}, longint'(tx_start), 0);
        chk({tag, "_tx_data"}, longint'(tx_data), 0);
        chk({tag, "_tx_eom"}, longint'(tx_eom), 0);
        chk({tag, "_tx_broadcast"}, longint'(tx_broadcast), 0);
        chk({tag, "_frame_ok"}, longint'(frame_ok), 0);
        chk({tag, "_frame_fail"}, longint'(frame_fail), 0);
        chk({tag, "_retry_count"}, longint'(retry_count), 0);
    endtask

    task automatic reset_mid_frame();
        longint s;
        bit     got;
        start_t se;
        write_all();
        frame_len = 5'd3;
        send = 1'b1;
        tick();
        s = cyc;
        send = 1'b0;
        se.cyc = s + FREE_NEW; se.data = mbuf[0]; se.eom = 1'b0;
        se.bc = (mbuf[0][3:0] == 4'hF);
        sq.push_back(se);
        wait_start(got);
        chk("abort_first_launch_seen", longint'(got), 1);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        tick();
        tick();
        rst = 1'b0;
        tx_done  = 1'b1;
        tx_acked = 1'b1;
        tick();
        tx_done  = 1'b0;
        repeat (FREE_NEW + 10) tick();
        chk("abort_busy_stays_low", longint'(busy), 0);
        chk("abort_no_queued", longint'(sq.size() + eq.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int r, len;
        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        write_all();

        // Two-byte frame, all acknowledged.
        write_byte(0, 8'h04);
        write_byte(1, 8'h36);
        run_frame(2, 3, 0);

        // Broadcast header on every byte.
        write_byte(0, 8'h4F);
        run_frame(4, 3, 0);

        // First byte NAKed once, then acknowledged.
        write_all();
        run_frame(3, 2, 0);

        // Every byte NAKed.
        run_frame(2, 1, 0);

        // Line pulled low during the free time.
        run_frame(3, 3, 2);

        // Length boundaries.
        run_frame(0, 3, 0);
        run_frame(17, 3, 0);
        run_frame(16, 3, 0);
        run_frame(1, 3, 0);

        reset_mid_frame();

        for (int f = 0; f < 30; f++) begin
            write_all();
            r = $urandom_range(0, 19);
            if (r == 0)      len = 0;
            else if (r == 1) len = $urandom_range(17, 31);
            else             len = $urandom_range(1, 16);
            run_frame(len, (r % 4 == 0) ? 1 : 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
